// File: rtl/jtag_host_if.sv
`timescale 1ns/1ps
// Command/response handshake bundle between a JTAG scan requester and jtag_host.
interface jtag_host_if #(
    parameter int MAX_LEN = 32
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_ir;
    logic [5:0]         cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_err;
    logic [MAX_LEN-1:0] rsp_data;

    // Requester side: offers scan commands, consumes responses.
    modport master (
        output cmd_valid, cmd_ir, cmd_len, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_err, rsp_data
    );

    // Host side: accepts scan commands, produces responses.
    modport slave (
        input  cmd_valid, cmd_ir, cmd_len, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_err, rsp_data
    );
endinterface

// File: rtl/jtag_host.sv
`timescale 1ns/1ps
// jtag_host: probe-side JTAG master. Runs the TAP through a reset sequence, then
// executes one IR or DR scan per accepted command (Idle -> Shift -> Idle) and
// returns the TDO bits captured during the shift as a right-aligned word.
module jtag_host #(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    jtag_host_if.slave bus,
    output logic       tck,
    output logic       tms,
    output logic       tdi,
    input  logic       tdo,
    output logic       busy
);
    localparam int               DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [6:0]       MAX_LEN_W = 7'(MAX_LEN);

    typedef enum logic [2:0] {
        S_TAP_RST,
        S_IDLE,
        S_PRE,
        S_SHIFT,
        S_TAIL,
        S_RESP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic [5:0]         cnt;
    logic [5:0]         len_q;
    logic               ir_q;
    logic               err_q;
    logic [MAX_LEN-1:0] data_sh;
    logic [MAX_LEN-1:0] capture;
    logic [6:0]         shamt;
    logic               ticking;
    logic               tck_rise;
    logic               tick_end;
    logic               last_tick;
    logic               accept;
    logic               len_bad;

    // A tick is CLK_DIV cycles with TCK low followed by CLK_DIV cycles high.
    assign ticking  = (state == S_TAP_RST) || (state == S_PRE) ||
                      (state == S_SHIFT) || (state == S_TAIL);
    assign tck_rise = ticking && (div_cnt == DIV_LAST) && !tck;
    assign tick_end = ticking && (div_cnt == DIV_LAST) && tck;

    assign bus.cmd_ready = (state == S_IDLE) && !bus.rsp_valid;
    assign busy          = (state != S_IDLE);
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign len_bad       = (bus.cmd_len == 6'd0) || ({1'b0, bus.cmd_len} > MAX_LEN_W);
    assign shamt         = MAX_LEN_W - {1'b0, len_q};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_TAP_RST;
        else     state <= state_nxt;
    end

    // Next state: each scan phase ends on the falling TCK edge of its last tick.
    always_comb begin
        state_nxt = state;
        last_tick = 1'b0;
        case (state)
            S_TAP_RST: begin
                last_tick = (cnt == 6'd5);
                if (tick_end && last_tick) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (accept) state_nxt = len_bad ? S_RESP : S_PRE;
            end
            S_PRE: begin
                last_tick = (cnt == (ir_q ? 6'd3 : 6'd2));
                if (tick_end && last_tick) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                last_tick = (cnt == len_q - 6'd1);
                if (tick_end && last_tick) state_nxt = S_TAIL;
            end
            S_TAIL: begin
                last_tick = (cnt == 6'd1);
                if (tick_end && last_tick) state_nxt = S_RESP;
            end
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_TAP_RST;
        endcase
    end

    // TCK generation, TMS/TDI for the upcoming tick, and the response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tck           <= 1'b0;
            tms           <= 1'b1;
            tdi           <= 1'b0;
            div_cnt       <= '0;
            cnt           <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_data  <= '0;
        end else begin
            if (ticking) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    tck     <= ~tck;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end else begin
                div_cnt <= '0;
            end

            if (tick_end) begin
                cnt <= last_tick ? 6'd0 : cnt + 6'd1;
                case (state)
                    S_TAP_RST: tms <= !last_tick && (cnt != 6'd4);
                    S_PRE: begin
                        if (last_tick) begin
                            tms <= (len_q == 6'd1);
                            tdi <= data_sh[0];
                        end else begin
                            // IR preamble is 1,1,0,0; DR preamble is 1,0,0.
                            tms <= ir_q && (cnt == 6'd0);
                        end
                    end
                    S_SHIFT: begin
                        if (last_tick) begin
                            tms <= 1'b1;
                            tdi <= 1'b0;
                        end else begin
                            tms <= (cnt + 6'd2 == len_q);
                            tdi <= data_sh[0];
                        end
                    end
                    default: tms <= 1'b0;
                endcase
            end

            if (state == S_IDLE && accept) begin
                cnt <= '0;
                tms <= !len_bad;
                tdi <= 1'b0;
            end

            if (state == S_RESP) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_err   <= err_q;
                bus.rsp_data  <= err_q ? '0 : (capture >> shamt);
            end else if (bus.rsp_valid && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
                bus.rsp_err   <= 1'b0;
            end
        end
    end

    // Command latch, TDI source shifter and TDO capture (first bit ends up lowest).
    always_ff @(posedge clk) begin
        if (state == S_IDLE && accept) begin
            len_q   <= bus.cmd_len;
            ir_q    <= bus.cmd_ir;
            err_q   <= len_bad;
            data_sh <= bus.cmd_data;
            capture <= '0;
        end else begin
            if (tick_end && ((state == S_PRE && last_tick) ||
                             (state == S_SHIFT && !last_tick))) begin
                data_sh <= data_sh >> 1;
            end
            if (tck_rise && state == S_SHIFT) begin
                capture <= {tdo, capture[MAX_LEN-1:1]};
            end
        end
    end
endmodule

// File: tb/tb_jtag_host.sv
`timescale 1ns/1ps
// Bench for jtag_host: a behavioural TAP (IR=4 bits, IDCODE=0xF0F0F0F0,
// BYPASS=0xF) hangs off one host instance; a second host with CLK_DIV=3 is
// used for the reset-during-shift scenario.
module tb_jtag_host;
    logic clk = 1'b0;
    logic rst1 = 1'b1;
    logic rst2 = 1'b1;
    logic tck1, tms1, tdi1, busy1;
    logic tck2, tms2, tdi2, busy2;
    logic tdo1 = 1'b0;
    logic tdo2 = 1'b1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;

    jtag_host_if #(.MAX_LEN(32)) bus1 ();
    jtag_host_if #(.MAX_LEN(32)) bus2 ();

    jtag_host #(.CLK_DIV(2), .MAX_LEN(32)) dut1 (
        .clk(clk), .rst(rst1), .bus(bus1),
        .tck(tck1), .tms(tms1), .tdi(tdi1), .tdo(tdo1), .busy(busy1)
    );

    jtag_host #(.CLK_DIV(3), .MAX_LEN(32)) dut2 (
        .clk(clk), .rst(rst2), .bus(bus2),
        .tck(tck2), .tms(tms2), .tdi(tdi2), .tdo(tdo2), .busy(busy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitors
    logic tms_q1[$];
    logic tms_q2[$];
    time  rise_t2[$];
    int   tck1_edges = 0;
    int   rises2 = 0;
    int   rv2_rises = 0;
    always @(posedge tck1) tms_q1.push_back(tms1);
    always @(posedge tck2) begin
        tms_q2.push_back(tms2);
        rise_t2.push_back($time);
        rises2++;
    end
    always @(tck1) tck1_edges++;
    always @(posedge bus2.rsp_valid) rv2_rises++;

    // Behavioural TAP target
    typedef enum logic [3:0] {
        TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
        SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR
    } tap_t;
    localparam logic [3:0]  IR_IDCODE = 4'h8;
    localparam logic [31:0] IDCODE    = 32'hF0F0F0F0;
    tap_t        tap   = TLR;
    logic [3:0]  ir    = IR_IDCODE;
    logic [3:0]  ir_sh = 4'h0;
    logic [31:0] dr_sh = 32'h0;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:  return m ? TLR  : RTI;
            RTI:  return m ? SDR  : RTI;
            SDR:  return m ? SIR  : CDR;
            CDR:  return m ? E1DR : SHDR;
            SHDR: return m ? E1DR : SHDR;
            E1DR: return m ? UDR  : PDR;
            PDR:  return m ? E2DR : PDR;
            E2DR: return m ? UDR  : SHDR;
            UDR:  return m ? SDR  : RTI;
            SIR:  return m ? TLR  : CIR;
            CIR:  return m ? E1IR : SHIR;
            SHIR: return m ? E1IR : SHIR;
            E1IR: return m ? UIR  : PIR;
            PIR:  return m ? E2IR : PIR;
            E2IR: return m ? UIR  : SHIR;
            default: return m ? SDR : RTI;
        endcase
    endfunction

    always @(posedge tck1) begin
        case (tap)
            TLR:  ir <= IR_IDCODE;
            CDR:  dr_sh <= (ir == IR_IDCODE) ? IDCODE : 32'h0;
            SHDR: begin
                if (ir == IR_IDCODE) dr_sh <= {tdi1, dr_sh[31:1]};
                else                 dr_sh[0] <= tdi1;
            end
            CIR:  ir_sh <= 4'h0;
            SHIR: ir_sh <= {tdi1, ir_sh[3:1]};
            UIR:  ir <= ir_sh;
            default: ;
        endcase
        tap <= tap_next(tap, tms1);
    end

    always @(negedge tck1) begin
        tdo1 <= (tap == SHDR) ? dr_sh[0] : (tap == SHIR) ? ir_sh[0] : 1'b0;
    end

    // Scoreboard
    typedef struct packed {
        logic        err;
        logic [31:0] data;
        logic [31:0] lat;
    } sb_t;
    sb_t sb_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_tms(input int sel, input string tag, input int start, input int n,
                             input logic [15:0] exp);
        logic [15:0] obs;
        int sz;
        obs = '0;
        sz = (sel == 1) ? tms_q1.size() : tms_q2.size();
        check({tag, "_ticks"}, 64'(sz - start), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (start + i < sz) obs[n-1-i] = (sel == 1) ? tms_q1[start+i] : tms_q2[start+i];
        end
        check(tag, {48'd0, obs}, {48'd0, exp});
    endtask

    task automatic send(input string tag, input logic ir_scan, input logic [5:0] len,
                        input logic [31:0] data, input logic exp_err,
                        input logic [31:0] exp_data, input int pre);
        int n;
        sb_t e;
        n = 0;
        while (bus1.cmd_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 64'(bus1.cmd_ready), 64'd1);
        bus1.cmd_valid = 1'b1;
        bus1.cmd_ir    = ir_scan;
        bus1.cmd_len   = len;
        bus1.cmd_data  = data;
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        bus1.cmd_valid = 1'b0;
        bus1.cmd_ir    = ~ir_scan;
        bus1.cmd_len   = 6'd1;
        bus1.cmd_data  = ~data;
        e.err  = exp_err;
        e.data = exp_data;
        e.lat  = exp_err ? 32'd1 : 32'((pre + int'(len) + 2) * 2 * 2 + 1);
        sb_q.push_back(e);
    endtask

    task automatic get_rsp(input string tag, input int hold);
        int  n;
        sb_t e;
        logic hold_bad;
        n = 0;
        hold_bad = 1'b0;
        while (bus1.rsp_valid !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_sb"}, 64'(sb_q.size()), 64'd1);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        check({tag, "_lat"}, 64'(cyc - acc_cyc), 64'(e.lat));
        check({tag, "_err"}, 64'(bus1.rsp_err), 64'(e.err));
        check({tag, "_data"}, 64'(bus1.rsp_data), 64'(e.data));
        if (hold > 0) begin
            bus1.cmd_valid = 1'b1;
            bus1.cmd_ir    = 1'b0;
            bus1.cmd_len   = 6'd4;
            bus1.cmd_data  = 32'h5;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (bus1.rsp_valid !== 1'b1 || bus1.cmd_ready !== 1'b0) hold_bad = 1'b1;
            end
            check({tag, "_hold"}, 64'(hold_bad), 64'd0);
        end
        bus1.cmd_valid = 1'b0;
        bus1.rsp_ready = 1'b1;
        @(negedge clk);
        bus1.rsp_ready = 1'b0;
        check({tag, "_clr"}, 64'({bus1.rsp_valid, bus1.rsp_err}), 64'd0);
        check({tag, "_keep"}, 64'(bus1.rsp_data), 64'(e.data));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int q0;
        int c0;
        int e0;
        int r0;
        int n;
        logic [31:0] rnd;

        bus1.cmd_valid = 1'b0; bus1.cmd_ir = 1'b0; bus1.cmd_len = 6'd0;
        bus1.cmd_data = '0;    bus1.rsp_ready = 1'b0;
        bus2.cmd_valid = 1'b0; bus2.cmd_ir = 1'b0; bus2.cmd_len = 6'd0;
        bus2.cmd_data = '0;    bus2.rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", 64'({tck1, tms1, tdi1, bus1.cmd_ready, bus1.rsp_valid,
                               bus1.rsp_err, busy1}), 64'(7'b0100001));
        check("rst_data", 64'(bus1.rsp_data), 64'd0);

        // TAP reset sequence after RST
        q0 = tms_q1.size();
        c0 = cyc;
        rst1 = 1'b0;
        rst2 = 1'b0;
        n = 0;
        while (bus1.cmd_ready !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("t1_ready_cyc", 64'(cyc - c0), 64'd24);
        check("t1_tck_idle", 64'({tck1, tms1, busy1}), 64'd0);
        check_tms(1, "t1_tms", q0, 6, 16'b111110);

        // IR scan selecting IDCODE
        q0 = tms_q1.size();
        send("t2", 1'b1, 6'd4, 32'h8, 1'b0, 32'h0, 4);
        get_rsp("t2", 0);
        check_tms(1, "t2_tms", q0, 10, 16'b1100000110);
        check("t2_ir", 64'(ir), 64'(IR_IDCODE));

        // IDCODE reads, full and partial length
        send("t3", 1'b0, 6'd32, 32'h0, 1'b0, IDCODE, 3);
        get_rsp("t3", 0);
        send("t3b", 1'b0, 6'd16, 32'h1234, 1'b0, {16'h0, IDCODE[15:0]}, 3);
        get_rsp("t3b", 0);

        // BYPASS: one-bit delay through the target
        send("t4ir", 1'b1, 6'd4, 32'hF, 1'b0, 32'h0, 4);
        get_rsp("t4ir", 0);
        check("t4_ir", 64'(ir), 64'h0F);
        send("t4", 1'b0, 6'd8, 32'hA5, 1'b0, 32'h4A, 3);
        get_rsp("t4", 0);
        rnd = $urandom;
        send("t4r", 1'b0, 6'd32, rnd, 1'b0, {rnd[30:0], 1'b0}, 3);
        get_rsp("t4r", 0);

        // Illegal lengths: immediate error response, no TCK activity
        e0 = tck1_edges;
        send("t5a", 1'b0, 6'd0, 32'hDEAD, 1'b1, 32'h0, 0);
        get_rsp("t5a", 10);
        check("t5a_no_tck", 64'(tck1_edges - e0), 64'd0);
        e0 = tck1_edges;
        send("t5b", 1'b1, 6'd33, 32'hBEEF, 1'b1, 32'h0, 0);
        get_rsp("t5b", 10);
        check("t5b_no_tck", 64'(tck1_edges - e0), 64'd0);

        // Normal operation resumes after errors
        send("t5c", 1'b1, 6'd4, 32'h8, 1'b0, 32'h0, 4);
        get_rsp("t5c", 0);
        send("t5d", 1'b0, 6'd32, 32'h0, 1'b0, IDCODE, 3);
        get_rsp("t5d", 0);

        // Reset in the middle of a shift, CLK_DIV=3 host
        n = 0;
        while (bus2.cmd_ready !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("t6_ready0", 64'(bus2.cmd_ready), 64'd1);
        bus2.cmd_valid = 1'b1;
        bus2.cmd_ir    = 1'b0;
        bus2.cmd_len   = 6'd8;
        bus2.cmd_data  = 32'h5A;
        @(posedge clk);
        @(negedge clk);
        bus2.cmd_valid = 1'b0;
        r0 = rises2;
        n = 0;
        while (!((rises2 - r0) >= 8 && tck2 === 1'b1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("t6_shift5", 64'(rises2 - r0), 64'd8);
        rst2 = 1'b1;
        @(negedge clk);
        check("t6_rst_out", 64'({tck2, tms2, tdi2, bus2.cmd_ready, bus2.rsp_valid, busy2}),
              64'(6'b010001));
        rst2 = 1'b0;
        q0 = tms_q2.size();
        e0 = rise_t2.size();
        c0 = cyc;
        n = 0;
        while (bus2.cmd_ready !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("t6_ready_cyc", 64'(cyc - c0), 64'd36);
        check_tms(2, "t6_tms", q0, 6, 16'b111110);
        check("t6_period", (rise_t2.size() > e0 + 1) ? 64'(rise_t2[e0+1] - rise_t2[e0]) : 64'd0,
              64'd60);
        repeat (5) @(negedge clk);
        check("t6_no_rsp", 64'({rv2_rises[7:0], bus2.rsp_valid}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
